// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pkg
// Description : Shared core package. Holds the instruction-width constant
//               and the fetch-controller state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

    // Width of one fetched instruction word.
    localparam int unsigned c_instr_width = 32;

    // Fetch controller states.
    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_ERR   = 3'd4
    } fetch_state_e;

endpackage : rv_pkg
`default_nettype wire

// File: rtl/rv_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rv_fetch_fifo
// Description : Circular FIFO holding fetched {pc, instruction} entries.
//               The head entry is presented combinationally from storage.
// Ports       : clk, rst_n         - clock, synchronous active-low reset
//               flush_i            - drop all entries (wins over push/pop)
//               push_i/push_data_i - write one entry at the tail
//               pop_i              - remove the head (ignored when empty)
//               head_valid_o       - FIFO not empty
//               head_data_o        - head entry
//               count_o            - number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module rv_fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic                     head_valid_o,
    output logic [WIDTH-1:0]         head_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned c_ptr_w = $clog2(DEPTH);
    localparam int unsigned c_cnt_w = $clog2(DEPTH) + 1;

    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0] count_q, count_d;
    logic               pop_ok;
    logic               push_ok;

    always_comb begin
        pop_ok   = pop_i & (count_q != '0);
        // A push into a full buffer is only possible when the head leaves
        // on the same edge; otherwise the caller's reservation was violated.
        push_ok  = push_i & ((count_q != c_cnt_full) | pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + c_ptr_one;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + c_ptr_one;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + c_cnt_one;
                2'b01:   count_d = count_q - c_cnt_one;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_valid_o = (count_q != '0);
    assign head_data_o  = mem_q[rd_ptr_q];
    assign count_o      = count_q;

endmodule : rv_fetch_fifo
`default_nettype wire

// File: rtl/rv_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rv_fetch_ctrl
// Description : Instruction fetch controller. Issues one instruction-memory
//               request at a time at the PC supplied by the PC unit, buffers
//               responses with their PC, discards in-flight responses after
//               a redirect and halts on a misaligned PC until redirected.
// Ports       : clk, rst_n                 - clock, synchronous active-low reset
//               pc_addr_i                  - current PC
//               redirect_i                 - taken branch/jump this cycle
//               pc_en_o                    - PC unit update enable
//               imem_req_o/imem_addr_o     - fetch request and byte address
//               imem_gnt_i                 - request accepted
//               imem_rvalid_i/imem_rdata_i - read response
//               instr_valid_o/instr_o/instr_pc_o - fetch buffer head
//               dec_ready_i                - decoder consumes the head
//               misalign_o                 - halted on misaligned PC
// Revision    : 1.0 - initial release
// ============================================================================
module rv_fetch_ctrl
    import rv_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned INSTR_WIDTH = c_instr_width,
    parameter int unsigned BUF_DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_WIDTH-1:0]  pc_addr_i,
    input  logic                   redirect_i,
    output logic                   pc_en_o,
    output logic                   imem_req_o,
    output logic [ADDR_WIDTH-1:0]  imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_rvalid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    output logic                   instr_valid_o,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0]  instr_pc_o,
    input  logic                   dec_ready_i,
    output logic                   misalign_o
);

    localparam int unsigned c_entry_w = ADDR_WIDTH + INSTR_WIDTH;
    localparam int unsigned c_cnt_w   = $clog2(BUF_DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_buf_full = c_cnt_w'(BUF_DEPTH);

    fetch_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pend_pc_q, pend_pc_d;

    logic [c_cnt_w-1:0]      buf_count;
    logic                    buf_head_valid;
    logic [c_entry_w-1:0]    buf_head_data;
    logic                    buf_push;
    logic                    buf_pop;
    logic                    pc_aligned;
    logic                    req;

    always_comb begin
        pc_aligned = (pc_addr_i[1:0] == 2'b00);
        // A request is only raised when a buffer slot is free, so the
        // matching response can always be pushed.
        req        = rst_n && (state_q == ST_REQ) && pc_aligned &&
                     (buf_count != c_buf_full) && !redirect_i;

        state_d   = state_q;
        pend_pc_d = pend_pc_q;
        buf_push  = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (redirect_i) begin
                    state_d = ST_REQ;
                end else if (!pc_aligned) begin
                    state_d = ST_ERR;
                end else if (req && imem_gnt_i) begin
                    state_d   = ST_WAIT;
                    pend_pc_d = pc_addr_i;
                end
            end
            ST_WAIT: begin
                if (redirect_i) begin
                    // A same-cycle response is simply discarded; otherwise
                    // the response still in flight must be swallowed later.
                    state_d = imem_rvalid_i ? ST_REQ : ST_FLUSH;
                end else if (imem_rvalid_i) begin
                    buf_push = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            ST_FLUSH: begin
                // Leaves only when the stale response arrives. A further
                // redirect does not change this: no new request is issued
                // while here, so the stale response is still the one owed.
                if (imem_rvalid_i) begin
                    state_d = ST_REQ;
                end
            end
            ST_ERR: begin
                if (redirect_i) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_BOOT;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign buf_pop = instr_valid_o & dec_ready_i;

    rv_fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (c_entry_w)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (redirect_i),
        .push_i       (buf_push),
        .push_data_i  ({pend_pc_q, imem_rdata_i}),
        .pop_i        (buf_pop),
        .head_valid_o (buf_head_valid),
        .head_data_o  (buf_head_data),
        .count_o      (buf_count)
    );

    // Outputs are forced low while reset is asserted, independent of the
    // registered state that has not yet been cleared.
    assign imem_req_o    = req;
    assign imem_addr_o   = pc_addr_i;
    assign pc_en_o       = rst_n & ((req & imem_gnt_i) | redirect_i);
    assign instr_valid_o = rst_n & buf_head_valid;
    assign instr_o       = buf_head_data[INSTR_WIDTH-1:0];
    assign instr_pc_o    = buf_head_data[c_entry_w-1:INSTR_WIDTH];
    assign misalign_o    = rst_n & (state_q == ST_ERR);

endmodule : rv_fetch_ctrl
`default_nettype wire

// File: tb/tb_rv_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_fetch_ctrl
// Description : Self-checking bench for rv_fetch_ctrl: directed scenarios
//               followed by randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_fetch_ctrl;

    localparam int unsigned AW    = 64;
    localparam int unsigned IW    = 32;
    localparam int unsigned DEPTH = 2;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] ins;
    } ent_t;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] pc_addr_i;
    logic          redirect_i;
    logic          pc_en_o;
    logic          imem_req_o;
    logic [AW-1:0] imem_addr_o;
    logic          imem_gnt_i;
    logic          imem_rvalid_i;
    logic [IW-1:0] imem_rdata_i;
    logic          instr_valid_o;
    logic [IW-1:0] instr_o;
    logic [AW-1:0] instr_pc_o;
    logic          dec_ready_i;
    logic          misalign_o;

    int checks   = 0;
    int failures = 0;

    rv_fetch_ctrl #(
        .ADDR_WIDTH  (AW),
        .INSTR_WIDTH (IW),
        .BUF_DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_addr_i     (pc_addr_i),
        .redirect_i    (redirect_i),
        .pc_en_o       (pc_en_o),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .dec_ready_i   (dec_ready_i),
        .misalign_o    (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        redirect_i    = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        dec_ready_i   = 1'b0;
    endtask

    // Leaves the DUT in its post-reset cycle with rst_n released.
    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        pc_addr_i  = '0;
        idle_inputs();
        redirect_i = 1'b1;
        imem_gnt_i = 1'b1;
        step();
        step();
        #1;
        checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req_o); end
        checks++; if (pc_en_o !== 1'b0) begin failures++; $display("FAIL rst_pc_en got=%b exp=0", pc_en_o); end
        checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL rst_ivalid got=%b exp=0", instr_valid_o); end
        checks++; if (misalign_o !== 1'b0) begin failures++; $display("FAIL rst_misalign got=%b exp=0", misalign_o); end
        idle_inputs();
    endtask

    task automatic test_first_fetch();
        apply_reset();
        pc_addr_i = 64'h0;
        #1;
        checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL boot_req got=%b exp=0", imem_req_o); end
        step();
        imem_gnt_i = 1'b1;
        #1;
        checks++; if (imem_req_o !== 1'b1) begin failures++; $display("FAIL ff_req got=%b exp=1", imem_req_o); end
        checks++; if (imem_addr_o !== 64'h0) begin failures++; $display("FAIL ff_addr got=%h exp=0", imem_addr_o); end
        checks++; if (pc_en_o !== 1'b1) begin failures++; $display("FAIL ff_pc_en got=%b exp=1", pc_en_o); end
        step();
        imem_gnt_i    = 1'b0;
        pc_addr_i     = 64'h4;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h0000_0013;
        #1;
        checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL ff_wait_req got=%b exp=0", imem_req_o); end
        checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL ff_wait_ivalid got=%b exp=0", instr_valid_o); end
        step();
        imem_rvalid_i = 1'b0;
        #1;
        checks++; if (instr_valid_o !== 1'b1) begin failures++; $display("FAIL ff_ivalid got=%b exp=1", instr_valid_o); end
        checks++; if (instr_o !== 32'h0000_0013) begin failures++; $display("FAIL ff_instr got=%h exp=00000013", instr_o); end
        checks++; if (instr_pc_o !== 64'h0) begin failures++; $display("FAIL ff_instr_pc got=%h exp=0", instr_pc_o); end
        checks++; if (imem_req_o !== 1'b1) begin failures++; $display("FAIL ff_next_req got=%b exp=1", imem_req_o); end
        dec_ready_i = 1'b1;
        step();
        dec_ready_i = 1'b0;
        #1;
        checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL ff_popped got=%b exp=0", instr_valid_o); end
    endtask

    task automatic test_buffer_full();
        logic [AW-1:0] tb_pc;
        int grants;
        apply_reset();
        tb_pc  = '0;
        grants = 0;
        for (int i = 0; i < 10; i++) begin
            pc_addr_i     = tb_pc;
            imem_gnt_i    = 1'b1;
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = 32'hA000 + 32'(grants);
            dec_ready_i   = 1'b0;
            #1;
            if (imem_req_o === 1'b1) begin
                grants++;
                tb_pc = tb_pc + 64'd4;
            end
            step();
        end
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        pc_addr_i     = tb_pc;
        #1;
        checks++; if (grants !== 2) begin failures++; $display("FAIL full_grants got=%0d exp=2", grants); end
        checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL full_req got=%b exp=0", imem_req_o); end
        checks++; if (instr_pc_o !== 64'h0) begin failures++; $display("FAIL full_head_pc got=%h exp=0", instr_pc_o); end
        checks++; if (instr_o !== 32'hA001) begin failures++; $display("FAIL full_head_instr got=%h exp=a001", instr_o); end
        dec_ready_i = 1'b1;
        #1;
        checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL full_pop_req got=%b exp=0", imem_req_o); end
        step();
        dec_ready_i = 1'b0;
        pc_addr_i   = 64'h8;
        #1;
        checks++; if (instr_pc_o !== 64'h4) begin failures++; $display("FAIL full_second_pc got=%h exp=4", instr_pc_o); end
        checks++; if (instr_o !== 32'hA002) begin failures++; $display("FAIL full_second_instr got=%h exp=a002", instr_o); end
        checks++; if (imem_req_o !== 1'b1) begin failures++; $display("FAIL full_resume_req got=%b exp=1", imem_req_o); end
        checks++; if (imem_addr_o !== 64'h8) begin failures++; $display("FAIL full_resume_addr got=%h exp=8", imem_addr_o); end
    endtask

    task automatic test_redirect_wait();
        apply_reset();
        pc_addr_i = 64'h8;
        step();
        imem_gnt_i = 1'b1;
        #1;
        checks++; if (imem_addr_o !== 64'h8) begin failures++; $display("FAIL rw_addr got=%h exp=8", imem_addr_o); end
        step();
        imem_gnt_i = 1'b0;
        pc_addr_i  = 64'hC;
        redirect_i = 1'b1;
        #1;
        checks++; if (pc_en_o !== 1'b1) begin failures++; $display("FAIL rw_pc_en got=%b exp=1", pc_en_o); end
        step();
        redirect_i = 1'b0;
        pc_addr_i  = 64'h200;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = 32'hDEAD_BEEF;
            end
            #1;
            checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL rw_flush_req[%0d] got=%b exp=0", i, imem_req_o); end
            step();
        end
        imem_rvalid_i = 1'b0;
        #1;
        checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL rw_ivalid got=%b exp=0", instr_valid_o); end
        checks++; if (imem_req_o !== 1'b1) begin failures++; $display("FAIL rw_req got=%b exp=1", imem_req_o); end
        checks++; if (imem_addr_o !== 64'h200) begin failures++; $display("FAIL rw_target got=%h exp=200", imem_addr_o); end
    endtask

    task automatic test_redirect_rvalid();
        apply_reset();
        pc_addr_i = 64'hC;
        step();
        imem_gnt_i = 1'b1;
        #1;
        step();
        imem_gnt_i    = 1'b0;
        pc_addr_i     = 64'h10;
        redirect_i    = 1'b1;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h0000_0055;
        #1;
        checks++; if (pc_en_o !== 1'b1) begin failures++; $display("FAIL rr_pc_en got=%b exp=1", pc_en_o); end
        step();
        redirect_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        pc_addr_i     = 64'h40;
        #1;
        checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL rr_ivalid got=%b exp=0", instr_valid_o); end
        checks++; if (imem_req_o !== 1'b1) begin failures++; $display("FAIL rr_req got=%b exp=1", imem_req_o); end
        checks++; if (imem_addr_o !== 64'h40) begin failures++; $display("FAIL rr_addr got=%h exp=40", imem_addr_o); end
    endtask

    task automatic test_misalign();
        apply_reset();
        pc_addr_i = 64'h6;
        step();
        #1;
        checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL ma_req got=%b exp=0", imem_req_o); end
        checks++; if (pc_en_o !== 1'b0) begin failures++; $display("FAIL ma_pc_en got=%b exp=0", pc_en_o); end
        step();
        #1;
        checks++; if (misalign_o !== 1'b1) begin failures++; $display("FAIL ma_flag got=%b exp=1", misalign_o); end
        checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL ma_err_req got=%b exp=0", imem_req_o); end
        redirect_i = 1'b1;
        #1;
        checks++; if (pc_en_o !== 1'b1) begin failures++; $display("FAIL ma_redir_pc_en got=%b exp=1", pc_en_o); end
        step();
        redirect_i = 1'b0;
        pc_addr_i  = 64'h100;
        #1;
        checks++; if (misalign_o !== 1'b0) begin failures++; $display("FAIL ma_clear got=%b exp=0", misalign_o); end
        checks++; if (imem_req_o !== 1'b1) begin failures++; $display("FAIL ma_resume_req got=%b exp=1", imem_req_o); end
        checks++; if (imem_addr_o !== 64'h100) begin failures++; $display("FAIL ma_resume_addr got=%h exp=100", imem_addr_o); end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        pc_addr_i = 64'h0;
        step();
        imem_gnt_i = 1'b1;
        #1;
        step();
        imem_gnt_i = 1'b0;
        pc_addr_i  = 64'h4;
        rst_n      = 1'b0;
        #1;
        checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL rmw_req got=%b exp=0", imem_req_o); end
        step();
        rst_n         = 1'b1;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h0000_0077;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) imem_rvalid_i = 1'b0;
            #1;
            checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL rmw_ivalid[%0d] got=%b exp=0", i, instr_valid_o); end
            step();
        end
    endtask

    // Randomized traffic. The model tracks the fetch pipeline as a few
    // abstract facts (booting, halted, response owed, response to discard)
    // plus a queue of buffered {pc, instr} entries.
    task automatic test_random(input int n);
        ent_t          mq[$];
        bit            m_boot, m_halt, m_wait, m_drop;
        logic [AW-1:0] m_pend, m_pc, target;
        bit            do_rst, redir, gnt, rv, rdy;
        bit            e_req, e_pcen, e_iv, e_mis;
        logic [IW-1:0] rdata;
        apply_reset();
        mq.delete();
        m_boot = 1; m_halt = 0; m_wait = 0; m_drop = 0;
        m_pend = '0; m_pc = 64'h1000;
        for (int i = 0; i < n; i++) begin
            do_rst = ($urandom_range(0, 199) == 0);
            redir  = ($urandom_range(0, 11) == 0);
            gnt    = ($urandom_range(0, 1) == 1);
            rv     = (m_wait || m_drop) ? ($urandom_range(0, 2) == 0)
                                        : ($urandom_range(0, 7) == 0);
            if (m_drop && rv) redir = 0;
            rdy    = ($urandom_range(0, 1) == 1);
            rdata  = $urandom;
            target = {32'h0, $urandom};
            target[1:0] = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00;

            rst_n         = !do_rst;
            pc_addr_i     = m_pc;
            redirect_i    = redir;
            imem_gnt_i    = gnt;
            imem_rvalid_i = rv;
            imem_rdata_i  = rdata;
            dec_ready_i   = rdy;
            #1;

            if (do_rst) begin
                e_req = 0; e_pcen = 0; e_iv = 0; e_mis = 0;
            end else begin
                e_req  = !m_boot && !m_halt && !m_wait && !m_drop &&
                         (m_pc[1:0] == 2'b00) && (mq.size() < DEPTH) && !redir;
                e_pcen = (e_req && gnt) || redir;
                e_iv   = (mq.size() > 0);
                e_mis  = m_halt;
            end

            checks++; if (imem_req_o !== e_req) begin failures++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", i, imem_req_o, e_req); end
            checks++; if (imem_addr_o !== m_pc) begin failures++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", i, imem_addr_o, m_pc); end
            checks++; if (pc_en_o !== e_pcen) begin failures++; $display("FAIL rnd_pc_en cyc=%0d got=%b exp=%b", i, pc_en_o, e_pcen); end
            checks++; if (instr_valid_o !== e_iv) begin failures++; $display("FAIL rnd_ivalid cyc=%0d got=%b exp=%b", i, instr_valid_o, e_iv); end
            checks++; if (misalign_o !== e_mis) begin failures++; $display("FAIL rnd_misalign cyc=%0d got=%b exp=%b", i, misalign_o, e_mis); end
            if (e_iv) begin
                checks++; if (instr_o !== mq[0].ins) begin failures++; $display("FAIL rnd_instr cyc=%0d got=%h exp=%h", i, instr_o, mq[0].ins); end
                checks++; if (instr_pc_o !== mq[0].pc) begin failures++; $display("FAIL rnd_instr_pc cyc=%0d got=%h exp=%h", i, instr_pc_o, mq[0].pc); end
            end

            if (do_rst) begin
                mq.delete();
                m_boot = 1; m_halt = 0; m_wait = 0; m_drop = 0; m_pend = '0;
            end else if (redir) begin
                mq.delete();
                if (m_wait && !rv) m_drop = 1;
                m_wait = 0; m_halt = 0; m_boot = 0;
                m_pc   = target;
            end else begin
                if (e_iv && rdy) void'(mq.pop_front());
                if (m_boot) begin
                    m_boot = 0;
                end else if (m_halt) begin
                    m_halt = 1;
                end else if (m_wait) begin
                    if (rv) begin
                        mq.push_back('{pc: m_pend, ins: rdata});
                        m_wait = 0;
                    end
                end else if (m_drop) begin
                    if (rv) m_drop = 0;
                end else if (m_pc[1:0] != 2'b00) begin
                    m_halt = 1;
                end else if (e_req && gnt) begin
                    m_wait = 1;
                    m_pend = m_pc;
                    m_pc   = m_pc + 64'd4;
                end
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        rst_n     = 1'b0;
        pc_addr_i = '0;
        idle_inputs();
        test_reset();
        test_first_fetch();
        test_buffer_full();
        test_redirect_wait();
        test_redirect_rvalid();
        test_misalign();
        test_reset_mid_wait();
        test_random(4000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rv_fetch_ctrl
`default_nettype wire
